multi_sync_gen: RTL and testbench
=================================

# multi_sync_gen

Multi-channel, run-time programmable synchronisation-signal generator; successor to the single fixed-rate square-wave sync output. Each of N_CH channels produces a periodic output with independently programmable period, high time and start phase. All channels share one clock and can be restarted phase-aligned by a single start pulse. Sits between the board clock and the external sync/trigger pins. Configuration comes from the host-side register interface.

## Interface
- N_CH, 4, number of output channels (1..16)
- CNT_W, 32, counter and configuration width
- FREQ_CLK, 2000000, reset-default half period in clk cycles. Default period is 2*FREQ_CLK, default high time is FREQ_CLK, default phase is 0. Must fit CNT_W.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  global run enable
- ch_en  in  N_CH  per-channel run enable
- start  in  1  one-cycle pulse: load shadow config, restart all channels at their phase
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  $clog2(N_CH) (min 1)  target channel
- cfg_sel  in  2  field select: 0 = period, 1 = high, 2 = phase, 3 = reserved
- cfg_data  in  CNT_W  write data
- cfg_err  out  1  one-cycle pulse when a write is rejected
- syncout  out  N_CH  generated sync outputs
- edge_pulse  out  N_CH  one-cycle pulse on each syncout rising edge

## Operation
- Each channel keeps two register sets.
  - Shadow registers P_s, H_s, Ph_s: written by the host.
  - Active registers P, H, Ph: drive the counter.
- cfg_we writes cfg_data into the selected shadow field.
- A write is rejected (shadow unchanged, cfg_err=1 on the next cycle) when cfg_ch >= N_CH or cfg_sel == 3.
- Shadow is copied to active in two cases:
  - at a channel wrap (cnt == P-1 advancing to 0);
  - on start, for all channels.
- A write in the same cycle as a wrap or start is bypassed, so the new value is the one made active.
- Channel runs (run_i) when enable & ch_en[i].
- Counter rules:
  - Running: cnt <= (cnt == Pe-1) ? 0 : cnt+1.
  - Not running: cnt holds.
  - start: cnt <= Ph' for every channel, regardless of run, where Ph' = Ph_s if Ph_s < Pe, else 0.
- Effective period Pe = max(P, 2). Periods 0 and 1 behave as 2.
- syncout[i] is registered: syncout <= run_i & (cnt_next < H).
  - H == 0 gives a constant-low output.
  - H >= Pe gives a constant-high output while running.
- edge_pulse[i] <= syncout_next & ~syncout, registered alongside syncout.
- Dropping enable or ch_en[i] forces syncout and edge_pulse low on the next edge. The counter freezes. Re-enabling resumes from the frozen count; only start re-aligns channels.
- All comparisons are unsigned at CNT_W. No counter ever exceeds Pe-1.

## Timing
- Reset values:
  - cnt = 0;
  - active and shadow registers = defaults (P = 2*FREQ_CLK, H = FREQ_CLK, Ph = 0);
  - syncout = 0, edge_pulse = 0, cfg_err = 0.
- Latency:
  - start sampled at edge k: syncout reflects (Ph' < H) at edge k (registered output visible after k).
  - Config write at edge k: visible in active at the next wrap or start, edge >= k.
- A running channel has exactly Pe cycles per period, with syncout high for min(H, Pe) of them.
- Simultaneous events:
  - start overrides a wrap in the same cycle.
  - start and a write in the same cycle: the written value is used.
  - A rejected write never alters any channel.
- Reset asserted mid-period: all outputs go low immediately (asynchronous) and registers return to defaults. Sequencing after deassertion is fully synchronous.

## Structure
- Package sync_gen_pkg holds:
  - field encodings CFG_PERIOD = 0, CFG_HIGH = 1, CFG_PHASE = 2;
  - MIN_PERIOD = 2.
- Sub-module sync_channel: one channel, containing shadow/active registers, counter, output and edge registers. It is instantiated N_CH times in a generate loop.
- The top level contains address decode, cfg_err generation and enable fan-out only.

## Test plan
- Reset defaults, FREQ_CLK=3, enable=1, ch_en=all ones, no writes -> each syncout is a square wave of period 6, high 3. edge_pulse asserts once per 6 cycles.
- Write ch0 P=4, H=1, Ph=0 and ch1 P=4, H=1, Ph=2, then pulse start -> ch0 pattern 1,0,0,0 repeating; ch1 is the same pattern lagging by 2 cycles, starting aligned at the start edge.
- Write ch0 P=10 mid-period -> old period completes; the new 10-cycle period begins exactly at the next wrap. Repeat with the write landing on the wrap cycle -> takes effect at that wrap.
- Boundaries: P=0 -> period 2; H=0 -> constant low with no edge_pulse; H=P=5 -> constant high; Ph=7 with P=5 -> start loads 0.
- Write with cfg_ch=N_CH and with cfg_sel=3 -> cfg_err pulses 1 cycle; no channel changes.
- Drop enable for 5 cycles mid-period -> syncout=0 during the gap, resumes from the frozen count. Assert reset mid-run -> syncout=0 immediately, defaults restored.

Source files
------------

// File: rtl/sync_gen_pkg.sv
// Shared encodings for the multi-channel sync generator.
package sync_gen_pkg;

   typedef enum logic [1:0] {
      CFG_PERIOD = 2'd0,
      CFG_HIGH   = 2'd1,
      CFG_PHASE  = 2'd2,
      CFG_RSVD   = 2'd3
   } cfg_sel_e;

   localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/sync_channel.sv
// One sync channel: shadow/active config, phase counter, registered output and edge pulse.
module sync_channel
   import sync_gen_pkg::*;
#(
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned FREQ_CLK = 2000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             start,
   input  logic             wr_en,
   input  cfg_sel_e         wr_sel,
   input  logic [CNT_W-1:0] wr_data,
   output logic             syncout,
   output logic             edge_pulse
);

   localparam logic [CNT_W-1:0] DEF_P = CNT_W'(2 * FREQ_CLK);
   localparam logic [CNT_W-1:0] DEF_H = CNT_W'(FREQ_CLK);

   function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p);
      return (p < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : p;
   endfunction

   logic [CNT_W-1:0] ps_q, hs_q, phs_q, ps_d, hs_d, phs_d;
   logic [CNT_W-1:0] p_q, h_q, p_d, h_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync_q, sync_d, edge_q, edge_d;
   logic [CNT_W-1:0] pe_new;
   logic             wrap;

   // Active phase is only ever consumed at the instant of a start, straight from
   // the (bypassed) shadow, so no separate active phase register is kept.
   always_comb begin
      ps_d  = ps_q;
      hs_d  = hs_q;
      phs_d = phs_q;
      if (wr_en) begin
         case (wr_sel)
            CFG_PERIOD: ps_d  = wr_data;
            CFG_HIGH:   hs_d  = wr_data;
            CFG_PHASE:  phs_d = wr_data;
            default:    ;
         endcase
      end

      p_d    = p_q;
      h_d    = h_q;
      cnt_d  = cnt_q;
      pe_new = eff_period(ps_d);
      wrap   = run && (cnt_q == eff_period(p_q) - CNT_W'(1));

      if (start) begin
         p_d   = ps_d;
         h_d   = hs_d;
         cnt_d = (phs_d < pe_new) ? phs_d : '0;
      end else if (wrap) begin
         p_d   = ps_d;
         h_d   = hs_d;
         cnt_d = '0;
      end else if (run) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      sync_d = run && (cnt_d < h_d);
      edge_d = sync_d && !sync_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps_q   <= DEF_P;
         hs_q   <= DEF_H;
         phs_q  <= '0;
         p_q    <= DEF_P;
         h_q    <= DEF_H;
         cnt_q  <= '0;
         sync_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         ps_q   <= ps_d;
         hs_q   <= hs_d;
         phs_q  <= phs_d;
         p_q    <= p_d;
         h_q    <= h_d;
         cnt_q  <= cnt_d;
         sync_q <= sync_d;
         edge_q <= edge_d;
      end
   end

   assign syncout    = sync_q;
   assign edge_pulse = edge_q;

endmodule

// File: rtl/multi_sync_gen.sv
// Multi-channel programmable sync generator: config decode, error flag, enable fan-out.
module multi_sync_gen
   import sync_gen_pkg::*;
#(
   parameter int unsigned N_CH     = 4,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned FREQ_CLK = 2000000,
   localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [N_CH-1:0]  ch_en,
   input  logic             start,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [1:0]       cfg_sel,
   input  logic [CNT_W-1:0] cfg_data,
   output logic             cfg_err,
   output logic [N_CH-1:0]  syncout,
   output logic [N_CH-1:0]  edge_pulse
);

   cfg_sel_e sel;
   logic     addr_ok, wr_ok;
   logic     cfg_err_q, cfg_err_d;

   always_comb begin
      sel       = cfg_sel_e'(cfg_sel);
      addr_ok   = (32'(cfg_ch) < N_CH) && (sel != CFG_RSVD);
      wr_ok     = cfg_we && addr_ok;
      cfg_err_d = cfg_we && !addr_ok;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cfg_err_q <= 1'b0;
      else        cfg_err_q <= cfg_err_d;
   end

   assign cfg_err = cfg_err_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      sync_channel #(
         .CNT_W    (CNT_W),
         .FREQ_CLK (FREQ_CLK)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .run        (enable && ch_en[i]),
         .start      (start),
         .wr_en      (wr_ok && (cfg_ch == CH_W'(i))),
         .wr_sel     (sel),
         .wr_data    (cfg_data),
         .syncout    (syncout[i]),
         .edge_pulse (edge_pulse[i])
      );
   end

endmodule

// File: tb/tb_multi_sync_gen.sv
// Randomised bench for multi_sync_gen against a per-channel period/phase model.
module tb_multi_sync_gen;

   localparam int unsigned N  = 3;
   localparam int unsigned W  = 16;
   localparam int unsigned FC = 3;

   logic          clk = 1'b0;
   logic          reset, enable, start, cfg_we, cfg_err;
   logic [N-1:0]  ch_en, syncout, edge_pulse;
   logic [1:0]    cfg_ch, cfg_sel;
   logic [W-1:0]  cfg_data;

   int unsigned n_pass = 0, n_total = 0;
   bit          chk_en = 1'b0;

   multi_sync_gen #(.N_CH(N), .CNT_W(W), .FREQ_CLK(FC)) dut (
      .clk(clk), .reset(reset), .enable(enable), .ch_en(ch_en), .start(start),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .cfg_err(cfg_err), .syncout(syncout), .edge_pulse(edge_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: each channel is a position within its current period.
   int unsigned s_p[N], s_h[N], s_ph[N], a_p[N], a_h[N], pos[N];
   bit          m_sync[N], m_edge[N], m_err;

   function automatic int unsigned eff(input int unsigned p);
      return (p < 2) ? 2 : p;
   endfunction

   task automatic m_reset();
      for (int c = 0; c < N; c++) begin
         s_p[c] = 2 * FC; s_h[c] = FC; s_ph[c] = 0;
         a_p[c] = 2 * FC; a_h[c] = FC; pos[c] = 0;
         m_sync[c] = 0; m_edge[c] = 0;
      end
      m_err = 0;
   endtask

   task automatic m_step();
      bit valid, run, ns;
      valid = cfg_we && (int'(cfg_ch) < N) && (cfg_sel != 2'd3);
      m_err = cfg_we && !valid;
      for (int c = 0; c < N; c++) begin
         run = enable && ch_en[c];
         if (valid && int'(cfg_ch) == c) begin
            if (cfg_sel == 2'd0) s_p[c] = cfg_data;
            else if (cfg_sel == 2'd1) s_h[c] = cfg_data;
            else s_ph[c] = cfg_data;
         end
         if (start) begin
            a_p[c] = s_p[c]; a_h[c] = s_h[c];
            pos[c] = (s_ph[c] < eff(s_p[c])) ? s_ph[c] : 0;
         end else if (run) begin
            pos[c] = (pos[c] + 1) % eff(a_p[c]);
            if (pos[c] == 0) begin
               a_p[c] = s_p[c]; a_h[c] = s_h[c];
            end
         end
         ns = run && (pos[c] < a_h[c]);
         m_edge[c] = ns && !m_sync[c];
         m_sync[c] = ns;
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) m_reset();
      else begin
         logic [N-1:0] es, ee;
         m_step();
         #1;
         for (int c = 0; c < N; c++) begin
            es[c] = m_sync[c]; ee[c] = m_edge[c];
         end
         if (chk_en) begin
            check("syncout", 32'(syncout), 32'(es));
            check("edge_pulse", 32'(edge_pulse), 32'(ee));
            check("cfg_err", 32'(cfg_err), 32'(m_err));
         end
      end
   end

   task automatic wr(input int ch, input int sel, input int data);
      cfg_ch = 2'(ch); cfg_sel = 2'(sel); cfg_data = W'(data); cfg_we = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   initial begin
      logic [15:0] v0, v1, v2, e0;
      bit          hit;
      reset = 1'b0; enable = 1'b1; ch_en = '1; start = 1'b0;
      cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
      #12;
      check("reset_syncout", 32'(syncout), 32'h0);
      check("reset_edge", 32'(edge_pulse), 32'h0);
      check("reset_err", 32'(cfg_err), 32'h0);
      @(negedge clk);
      reset = 1'b1; chk_en = 1'b1;

      // Default square wave: period 6, high 3.
      v0 = '0; e0 = '0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         v0[i] = syncout[0]; e0[i] = edge_pulse[0];
      end
      check("default_wave", 32'(v0[11:0]), 32'h8E3);
      check("default_edges", 32'(e0[11:0]), 32'h821);

      @(negedge clk);
      wr(0, 0, 4); wr(0, 1, 1); wr(0, 2, 0);
      wr(1, 0, 4); wr(1, 1, 1); wr(1, 2, 2);
      start = 1'b1;
      v0 = '0; v1 = '0;
      @(posedge clk); #1; v0[0] = syncout[0]; v1[0] = syncout[1];
      @(negedge clk); start = 1'b0;
      for (int i = 1; i < 8; i++) begin
         @(posedge clk); #1; v0[i] = syncout[0]; v1[i] = syncout[1];
      end
      check("start_ch0", 32'(v0[7:0]), 32'h11);
      check("start_ch1", 32'(v1[7:0]), 32'h44);

      // Period change mid-period: new 10-cycle period begins at the next wrap.
      @(negedge clk);
      start = 1'b1; e0 = '0;
      @(posedge clk); #1; e0[0] = edge_pulse[0];
      @(negedge clk); start = 1'b0; wr(0, 0, 10);
      e0[1] = 1'b0;
      for (int i = 2; i < 16; i++) begin
         if (i > 2) @(negedge clk);
         @(posedge clk); #1; e0[i] = edge_pulse[0];
      end
      check("period_change_edges", 32'(e0), 32'h4011);

      // Write landing on the wrap cycle takes effect at that wrap.
      hit = 0;
      for (int i = 0; i < 24 && !hit; i++) begin
         @(negedge clk);
         if (pos[0] == 9) hit = 1;
      end
      check("wrap_found", 32'(hit), 32'h1);
      wr(0, 0, 4);
      repeat (10) @(negedge clk);

      // Boundaries.
      wr(0, 0, 0); wr(0, 1, 0);
      wr(1, 0, 5); wr(1, 1, 5);
      wr(2, 0, 5); wr(2, 1, 1); wr(2, 2, 7);
      start = 1'b1;
      v0 = '0; v1 = '0; v2 = '0; e0 = '0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         v0[i] = syncout[0]; v1[i] = syncout[1]; v2[i] = syncout[2]; e0[i] = edge_pulse[0];
         @(negedge clk); start = 1'b0;
      end
      check("h0_low", 32'(v0[7:0]), 32'h00);
      check("h0_no_edge", 32'(e0[7:0]), 32'h00);
      check("h_eq_p_high", 32'(v1[7:0]), 32'hFF);
      check("phase_clamp", 32'(v2[7:0]), 32'h21);

      // Rejected writes.
      cfg_ch = 2'd3; cfg_sel = 2'd0; cfg_data = 16'd1; cfg_we = 1'b1;
      @(posedge clk); #1; check("err_bad_ch", 32'(cfg_err), 32'h1);
      @(negedge clk); cfg_ch = 2'd0; cfg_sel = 2'd3;
      @(posedge clk); #1; check("err_bad_sel", 32'(cfg_err), 32'h1);
      @(negedge clk); cfg_we = 1'b0;
      @(posedge clk); #1; check("err_clear", 32'(cfg_err), 32'h0);

      // Enable gap.
      @(negedge clk);
      wr(1, 1, 2); wr(2, 1, 3);
      repeat (3) @(negedge clk);
      enable = 1'b0; v0 = '0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1; v0[i] = |syncout | |edge_pulse;
      end
      check("gap_low", 32'(v0), 32'h0);
      @(negedge clk); enable = 1'b1;
      repeat (12) @(negedge clk);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         cfg_we   = ($urandom % 4) == 0;
         cfg_ch   = 2'($urandom % 4);
         cfg_sel  = 2'($urandom % 4);
         cfg_data = W'($urandom % 14);
         start    = ($urandom % 20) == 0;
         enable   = ($urandom % 30) != 0;
         if (($urandom % 25) == 0) ch_en = N'($urandom);
         @(negedge clk);
      end
      cfg_we = 1'b0; start = 1'b0; enable = 1'b1; ch_en = '1;
      repeat (5) @(negedge clk);

      // Asynchronous reset mid-run.
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      check("async_rst_sync", 32'(syncout), 32'h0);
      check("async_rst_edge", 32'(edge_pulse), 32'h0);
      check("async_rst_err", 32'(cfg_err), 32'h0);
      @(negedge clk); reset = 1'b1;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
